// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: UART transmit framing engine with a per-frame baud divider.
// Sends start, 8 data bits (LSB first), an optional parity bit and 1 or 2 stop bits.
// The divider restarts on every accepted byte, so each bit, including the first,
// lasts exactly DIV clock cycles.
module uart_tx_sequencer #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DIV         = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_odd,
  input  logic       cfg_stop2,
  output logic       tx,
  output logic       busy,
  output logic       baud_tick,
  output logic       frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Parity of a byte; odd selects odd parity (complement of the XOR reduction).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          stop2_q, stop2_d;
  logic          tx_q, tx_d;
  logic          frame_done_q, frame_done_d;
  logic          tick_s;

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tick_s     = busy && (cnt_q == CNT_LAST);
  assign baud_tick  = tick_s;
  assign tx         = tx_q;
  assign frame_done = frame_done_q;

  // State, divider, shift register, latched config and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shreg_q      <= 8'h00;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop2_q      <= 1'b0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_en_q     <= par_en_d;
      par_bit_q    <= par_bit_d;
      stop2_q      <= stop2_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: accept in IDLE, otherwise advance one bit per baud tick.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    stop2_d      = stop2_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;

    if (busy) begin
      cnt_d = tick_s ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          // Config and parity are frozen here so mid-frame changes cannot leak in.
          shreg_d   = tx_data;
          par_en_d  = cfg_parity_en;
          par_bit_d = parity_bit(tx_data, cfg_parity_odd);
          stop2_d   = cfg_stop2;
          idx_d     = 3'd0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          idx_d   = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          idx_d   = 3'd0;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick_s) begin
          // idx counts stop bits already completed; a second one only with stop2.
          if (stop2_q && (idx_q == 3'd0)) begin
            idx_d = 3'd1;
          end else begin
            idx_d        = 3'd0;
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer at default parameters (DIV = 434).
// Frames are described by a table of expected bit sequences; the sequence of
// each frame is pushed to a scoreboard queue on accept and popped at mid-bit.
module tb_uart_tx_sequencer;

  localparam int DIV = 50_000_000 / 115200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_stop2 = 1'b0;
  logic       tx;
  logic       busy;
  logic       baud_tick;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        po;
    logic        s2;
    logic        toggle;
    logic        hold;
    int          n;
    logic [11:0] bits;   // bit k of the frame is bits[11-k]
  } vec_t;

  vec_t vecs[6];

  uart_tx_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx             (tx),
    .busy           (busy),
    .baud_tick      (baud_tick),
    .frame_done     (frame_done)
  );

  // 100 MHz-style free-running clock for simulation.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one frame from the table; caller is in an IDLE cycle after a negedge.
  task automatic run_frame(input vec_t v, input string tag);
    int bit_err = 0;
    int tick_err = 0;
    int ticks = 0;
    int fd_err = 0;
    int busy_err = 0;
    logic expb;
    tx_data        = v.data;
    cfg_parity_en  = v.pe;
    cfg_parity_odd = v.po;
    cfg_stop2      = v.s2;
    tx_valid       = 1'b1;
    check({tag, "_ready_before"}, tx_ready, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < v.n; k++) exp_q.push_back(v.bits[11-k]);
    if (!v.hold) tx_valid = 1'b0;
    tx_data = 8'($urandom);
    for (int c = 0; c < v.n * DIV; c++) begin
      @(negedge clk);
      expb = v.bits[11 - (c / DIV)];
      if (tx !== expb) bit_err++;
      if (baud_tick !== ((c % DIV) == DIV - 1)) tick_err++;
      if (baud_tick === 1'b1) ticks++;
      if (frame_done !== 1'b0) fd_err++;
      if (busy !== 1'b1 || tx_ready !== 1'b0) busy_err++;
      if ((c % DIV) == DIV / 2)
        check($sformatf("%s_bit%0d", tag, c / DIV), tx, exp_q.pop_front());
      if (v.toggle && c == 3 * DIV) begin
        cfg_parity_en  = ~v.pe;
        cfg_parity_odd = ~v.po;
        cfg_stop2      = ~v.s2;
        tx_data        = 8'hFF;
        tx_valid       = 1'b1;
      end
      if (v.toggle && c == 4 * DIV) tx_valid = v.hold;
    end
    check({tag, "_tx_level_errs"}, bit_err, 0);
    check({tag, "_tick_pos_errs"}, tick_err, 0);
    check({tag, "_tick_count"}, ticks, v.n);
    check({tag, "_early_frame_done"}, fd_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    @(negedge clk);
    check({tag, "_frame_done_end"}, frame_done, 1);
    check({tag, "_tx_mark_end"}, tx, 1);
    check({tag, "_ready_end"}, tx_ready, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_tick_end"}, baud_tick, 0);
  endtask

  initial begin
    int rst_err;
    // data, pe, po, s2, toggle, hold, N, bit sequence (start first)
    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 12'b0101010101_00};
    vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12, 12'b0_11000101_0_11};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11, 12'b0_00000000_1_1_0};
    vecs[3] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 12'b0_11110000_1_00};
    vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 12'b0_00001111_1_00};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 12'b0_10000001_1_00};

    // Reset held for 5 cycles, then a few idle cycles after release.
    rst_err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 ||
          baud_tick !== 1'b0 || frame_done !== 1'b0) rst_err++;
    end
    check("reset_tx", tx, 1);
    check("reset_ready", tx_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 ||
          baud_tick !== 1'b0 || frame_done !== 1'b0) rst_err++;
    end
    check("reset_idle_errs", rst_err, 0);

    // Single frames, including a mid-frame config toggle.
    for (int i = 0; i < 3; i++) begin
      run_frame(vecs[i], $sformatf("f%0d", i));
      @(negedge clk);
      check($sformatf("f%0d_done_one_cycle", i), frame_done, 0);
      check($sformatf("f%0d_idle_tx", i), tx, 1);
    end

    // Back-to-back: valid stays high; the second accept follows one mark cycle.
    run_frame(vecs[3], "b2b0");
    run_frame(vecs[4], "b2b1");
    @(negedge clk);
    check("b2b_done_one_cycle", frame_done, 0);

    // Reset asserted during data bit 3 of a frame.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_tick", baud_tick, 0);
    rst_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) rst_err++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) rst_err++;
    end
    check("mid_rst_no_frame_done", rst_err, 0);
    run_frame(vecs[5], "post_rst");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

UART transmit sequencer that owns the baud timing for the transmit path. It accepts bytes over a valid/ready handshake and restarts an internal baud divider at the start of every frame, so the first bit is a full period. It then drives the serial line through start, data, optional parity and stop bits. It sits between the APB register block's TX holding logic and the `tx` pad, and uses the same divisor arithmetic as `uart_baud_rate_generator`.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, serial bit rate.
- `DIV`, CLK_FREQ_HZ/BAUD_RATE (integer division, 434 at defaults), clock cycles per bit. Must be ≥ 2. Counter width is $clog2(DIV).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  8  byte to send, sampled on accept.
- `tx_valid`  in  1  requester has a byte.
- `tx_ready`  out  1  high only in IDLE. Decoded from state, not registered.
- `cfg_parity_en`  in  1  1 = insert parity bit.
- `cfg_parity_odd`  in  1  1 = odd parity, 0 = even.
- `cfg_stop2`  in  1  1 = two stop bits, 0 = one.
- `tx`  out  1  serial line; idle/mark = 1.
- `busy`  out  1  high in every non-IDLE state.
- `baud_tick`  out  1  one-cycle pulse on the last cycle of each bit period while busy.
- `frame_done`  out  1  one-cycle pulse in the first IDLE cycle after a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Accept:** accept occurs on an edge where `tx_valid && tx_ready`. On accept:
  - latch `tx_data` into the shift register;
  - latch the three cfg bits;
  - clear the baud counter and the bit index;
  - go to START.
- **Config timing:** cfg inputs are ignored outside the accept edge. Changing them mid-frame has no effect.
- **Baud counter:** counts 0..DIV-1 while busy and wraps to 0. `baud_tick` = busy && (count == DIV-1). The counter is held at 0 in IDLE.
- **State transitions:** all non-IDLE transitions occur only on `baud_tick` edges.
  - START → DATA.
  - DATA: shift LSB first; index 0..7. After index 7 → PARITY if parity enabled, else STOP.
  - PARITY → STOP.
  - STOP: one or two bit periods. After the last one → IDLE, and assert `frame_done`.
- **`tx` value per state:**
  - IDLE: 1.
  - START: 0.
  - DATA: current data bit.
  - PARITY: ^data for even, ~^data for odd.
  - STOP: 1.
- **`tx` is registered.** It changes on the same edge as the state change.
- **Frame length:** N = 1 + 8 + P + S bits, with P ∈ {0,1} and S ∈ {1,2}. Total = N·DIV cycles.
- **While busy:** `tx_valid` is ignored and `tx_data` may change freely.
- **Reset:** asynchronous. Any in-flight frame is discarded with no partial stop bits.

## Timing
- **Reset values:**
  - state = IDLE;
  - `tx` = 1, `tx_ready` = 1, `busy` = 0, `baud_tick` = 0, `frame_done` = 0;
  - counter, bit index and shift register = 0.
- **Accept latency:** accept on edge E0 → `tx` = 0 from E0 until edge E0+DIV.
- Bit k (k = 0 for start) occupies the cycles between edges E0+k·DIV and E0+(k+1)·DIV.
- **End of frame:** at edge E0+N·DIV, the state becomes IDLE, `tx` = 1, and `frame_done` = 1 for that one cycle. `tx_ready` = 1 from the same cycle.
- **Back-to-back frames:** the earliest next accept is edge E0+N·DIV+1. This gives exactly one mark cycle between frames when `tx_valid` is held high.
- **`baud_tick` pulses:** N per frame, in the cycles just before edges E0+k·DIV for k = 1..N.
- **Reset mid-frame:** on `rst_n` falling, `tx` goes to 1 and `tx_ready` to 1 combinationally/asynchronously, with no clock required. The first accept after reset release behaves exactly like the first frame.

## Test plan
- **Reset:** hold `rst_n` = 0 for 5 cycles, `tx_valid` = 0 → `tx` = 1, `tx_ready` = 1, `busy` = 0 throughout and after release; `baud_tick` never pulses.
- **0x55, no parity, 1 stop:**
  - `tx` samples at mid-bit = 0,1,0,1,0,1,0,1,0,1, each bit exactly 434 cycles;
  - 10 `baud_tick` pulses, spaced 434 cycles apart;
  - `frame_done` pulses at accept+4340.
- **0xA3, even parity, 2 stop:**
  - data bits LSB first = 1,1,0,0,0,1,0,1;
  - parity = 0, then stop bits 1,1;
  - frame = 12 bits = 5208 cycles.
- **0x00, odd parity, 1 stop:** parity bit = 1; frame = 11 bits = 4774 cycles. Toggle all cfg inputs mid-frame → waveform unchanged.
- **Back-to-back:** `tx_valid` held high with 0x0F then 0xF0 →
  - exactly one cycle of `tx` = 1 between the last stop bit and the second start bit;
  - `tx_data` changes during the first frame do not corrupt it.
- **Mid-frame reset:** assert `rst_n` = 0 during data bit 3 →
  - `tx` = 1 and `busy` = 0 immediately, with no `frame_done`;
  - after release, a send of 0x81 produces a correct full frame.
